// File: rtl/bidir_bus_responder_if.sv
// bidir_bus_responder_if: control/status bundle of the bus responder; BIDIR_CONTENTION_DET_EN adds err_cnt.
interface bidir_bus_responder_if #(parameter int WIDTH = 8, parameter int ADDR_W = 3);
  logic ctrl, req, rsp_vld, wr_valid, busy, err;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
`ifdef BIDIR_CONTENTION_DET_EN
  logic [7:0] err_cnt;
  modport master(output ctrl, req, input rsp_vld, wr_valid, wr_addr, wr_data, busy, err, err_cnt);
  modport slave(input ctrl, req, output rsp_vld, wr_valid, wr_addr, wr_data, busy, err, err_cnt);
`else
  modport master(output ctrl, req, input rsp_vld, wr_valid, wr_addr, wr_data, busy, err);
  modport slave(input ctrl, req, output rsp_vld, wr_valid, wr_addr, wr_data, busy, err);
`endif
endinterface

// File: rtl/bidir_bus_responder.sv
// bidir_bus_responder: far-end register responder on a half-duplex tristate bus; BIDIR_CONTENTION_DET_EN enables contention detection.
module bidir_bus_responder #(
  parameter int WIDTH      = 8,
  parameter int ADDR_W     = 3,
  parameter int TURNAROUND = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [WIDTH-1:0] bus,
  bidir_bus_responder_if.slave sif
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int CW = TURNAROUND > 1 ? $clog2(TURNAROUND) : 1;
  localparam logic [CW-1:0] TA_LAST = CW'(TURNAROUND - 1);
  typedef enum logic [1:0] {IDLE, WR_DATA, TA, DRIVE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] regs [DEPTH];
  logic [ADDR_W-1:0] addr, addr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] rd_q, rd_n;
  logic drive_en, drive_n, wv_n, err_n, we;
  logic wr_valid_q, err_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [WIDTH-1:0] wr_data_q;
  assign bus = drive_en ? rd_q : 'z;
  assign sif.rsp_vld = drive_en;
  assign sif.busy = state != IDLE;
  assign sif.wr_valid = wr_valid_q;
  assign sif.wr_addr = wr_addr_q;
  assign sif.wr_data = wr_data_q;
  assign sif.err = err_q;
`ifdef BIDIR_CONTENTION_DET_EN
  logic cont;
  logic [7:0] err_cnt;
  assign sif.err_cnt = err_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_cnt <= '0;
    else if (cont && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
`endif
  always_comb begin
    state_n = state;
    addr_n = addr;
    cnt_n = cnt;
    rd_n = rd_q;
    drive_n = 1'b0;
    wv_n = 1'b0;
    err_n = 1'b0;
    we = 1'b0;
    case (state)
      IDLE: if (sif.ctrl && sif.req) begin
        addr_n = bus[ADDR_W-1:0];
        cnt_n = '0;
        state_n = bus[WIDTH-1] ? TA : WR_DATA;
      end
      WR_DATA: if (!sif.ctrl) begin
        err_n = 1'b1;
        state_n = IDLE;
      end else if (sif.req) begin
        we = 1'b1;
        wv_n = 1'b1;
        state_n = IDLE;
      end
      TA: if (cnt == TA_LAST) begin
        drive_n = 1'b1;
        rd_n = regs[addr];
        state_n = DRIVE;
      end else cnt_n = cnt + 1'b1;
      default: state_n = IDLE;
    endcase
`ifdef BIDIR_CONTENTION_DET_EN
    // far end still driving during our read slot: back off instead of fighting it
    cont = (state == TA || state == DRIVE) && sif.ctrl;
    if (cont) begin
      drive_n = 1'b0;
      err_n = 1'b1;
      state_n = IDLE;
    end
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      cnt <= '0;
      rd_q <= '0;
      drive_en <= 1'b0;
      wr_valid_q <= 1'b0;
      err_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      state <= state_n;
      addr <= addr_n;
      cnt <= cnt_n;
      rd_q <= rd_n;
      drive_en <= drive_n;
      wr_valid_q <= wv_n;
      err_q <= err_n;
      if (we) begin
        regs[addr] <= bus;
        wr_addr_q <= addr;
        wr_data_q <= bus;
      end
    end
endmodule

// File: tb/tb_bidir_bus_responder.sv
// tb_bidir_bus_responder: vector table plus read/write scoreboards; bus is pulled high so an undriven bus reads 0xFF.
module tb_bidir_bus_responder;
  logic clk = 1'b0, rst_n = 1'b0, tb_oe = 1'b0;
  logic [7:0] tb_d = '0;
  tri1 [7:0] bus;
  int checks = 0, errors = 0;
  logic [7:0] mem [8];
  logic [7:0] rq [$];
  logic [10:0] wq [$];
  bidir_bus_responder_if #(.WIDTH(8), .ADDR_W(3)) bif ();
  bidir_bus_responder #(.WIDTH(8), .ADDR_W(3), .TURNAROUND(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .sif(bif.slave));
  assign bus = tb_oe ? tb_d : 'z;
  always #5 clk = ~clk;
  typedef struct {
    logic ctrl, req, oe;
    logic [7:0] d;
    logic pw, pr;
    logic [2:0] a;
    logic busy, wv, err, rsp;
  } vec_t;
  vec_t vt [18];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic c, input logic r, input logic oe, input logic [7:0] d);
    bif.ctrl = c;
    bif.req = r;
    tb_oe = oe;
    tb_d = d;
  endtask
  task automatic flags(input string tag, input logic b, input logic wv, input logic e, input logic r);
    chk({tag, "_busy"}, bif.busy, b);
    chk({tag, "_wr_valid"}, bif.wr_valid, wv);
    chk({tag, "_err"}, bif.err, e);
    chk({tag, "_rsp_vld"}, bif.rsp_vld, r);
  endtask
  always @(negedge clk) begin
    if (bif.wr_valid) begin
      if (wq.size() == 0) chk("wr_unexpected", 1, 0);
      else chk("wr_commit", {bif.wr_addr, bif.wr_data}, wq.pop_front());
    end
    if (bif.rsp_vld) begin
      if (rq.size() == 0) chk("rd_unexpected", 1, 0);
      else chk("rd_data", bus, rq.pop_front());
    end else if (!tb_oe) chk("bus_z", bus, 8'hFF);
  end
  initial begin
    vt[0]  = '{1,1,1,8'h05,0,0,0, 1,0,0,0};
    vt[1]  = '{1,1,1,8'hA5,1,0,5, 0,1,0,0};
    vt[2]  = '{0,0,0,8'h00,0,0,0, 0,0,0,0};
    vt[3]  = '{1,1,1,8'h85,0,1,5, 1,0,0,0};
    vt[4]  = '{0,0,0,8'h00,0,0,0, 1,0,0,1};
    vt[5]  = '{0,0,0,8'h00,0,0,0, 0,0,0,0};
    vt[6]  = '{1,1,1,8'h02,0,0,0, 1,0,0,0};
    vt[7]  = '{0,0,0,8'h00,0,0,0, 0,0,1,0};
    vt[8]  = '{0,0,0,8'h00,0,0,0, 0,0,0,0};
    vt[9]  = '{1,1,1,8'h82,0,1,2, 1,0,0,0};
    vt[10] = '{0,0,0,8'h00,0,0,0, 1,0,0,1};
    vt[11] = '{0,0,0,8'h00,0,0,0, 0,0,0,0};
    vt[12] = '{1,1,1,8'h03,0,0,0, 1,0,0,0};
    vt[13] = '{1,0,1,8'h77,0,0,0, 1,0,0,0};
    vt[14] = '{1,1,1,8'h3C,1,0,3, 0,1,0,0};
    vt[15] = '{1,1,1,8'h83,0,1,3, 1,0,0,0};
    vt[16] = '{0,0,0,8'h00,0,0,0, 1,0,0,1};
    vt[17] = '{0,0,0,8'h00,0,0,0, 0,0,0,0};
    for (int i = 0; i < 8; i++) mem[i] = '0;
    drive(0, 0, 0, 0);
    #1;
    flags("reset", 0, 0, 0, 0);
    chk("reset_wr_addr", bif.wr_addr, 0);
    chk("reset_wr_data", bif.wr_data, 0);
    chk("reset_bus", bus, 8'hFF);
`ifdef BIDIR_CONTENTION_DET_EN
    chk("reset_err_cnt", bif.err_cnt, 0);
`endif
    tick;
    tick;
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      drive(1, 1, 1, 8'h80 | 8'(a));
      rq.push_back(mem[a]);
      tick;
      flags("init_cmd", 1, 0, 0, 0);
      drive(0, 0, 0, 0);
      tick;
      flags("init_drive", 1, 0, 0, 1);
      tick;
      flags("init_done", 0, 0, 0, 0);
    end
    for (int i = 0; i < 18; i++) begin
      drive(vt[i].ctrl, vt[i].req, vt[i].oe, vt[i].d);
      if (vt[i].pw) begin
        mem[vt[i].a] = vt[i].d;
        wq.push_back({vt[i].a, vt[i].d});
      end
      if (vt[i].pr) rq.push_back(mem[vt[i].a]);
      tick;
      flags($sformatf("vec%0d", i), vt[i].busy, vt[i].wv, vt[i].err, vt[i].rsp);
    end
    // far end keeps ctrl high through the turnaround slot
    drive(1, 1, 1, 8'h85);
`ifndef BIDIR_CONTENTION_DET_EN
    rq.push_back(mem[5]);
`endif
    tick;
    drive(1, 0, 0, 0);
    tick;
`ifdef BIDIR_CONTENTION_DET_EN
    flags("contention", 0, 0, 1, 0);
    chk("contention_err_cnt", bif.err_cnt, 1);
`else
    flags("no_contention_det", 1, 0, 0, 1);
`endif
    drive(0, 0, 0, 0);
    tick;
    flags("contention_after", 0, 0, 0, 0);
    drive(1, 1, 1, 8'h83);
    tick;
    drive(0, 0, 0, 0);
    tick;
    chk("pre_reset_rsp_vld", bif.rsp_vld, 1);
    chk("pre_reset_bus", bus, mem[3]);
    #2;
    rst_n = 1'b0;
    #1;
    flags("async_reset", 0, 0, 0, 0);
    chk("async_reset_bus", bus, 8'hFF);
    for (int i = 0; i < 8; i++) mem[i] = '0;
    tick;
    rst_n = 1'b1;
    drive(1, 1, 1, 8'h83);
    rq.push_back(mem[3]);
    tick;
    drive(0, 0, 0, 0);
    tick;
    flags("post_reset_drive", 1, 0, 0, 1);
    tick;
    tick;
    chk("rq_empty", rq.size(), 0);
    chk("wq_empty", wq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bidir_bus_responder.md
Name: bidir_bus_responder

Overview:
- Far-end responder on a shared half-duplex tristate bus; the opposite end of the ctrl-switched bidirectional buffer.
- Accepts write frames (command then data) while the far end drives the bus (ctrl=1).
- Answers read commands by driving register data after a turnaround gap, once the far end has released the bus (ctrl=0).
- Holds a small local register file and reports accepted writes to local logic.

Parameters:
- WIDTH, 8, bus and register word width.
- ADDR_W, 3, register address width; DEPTH = 2**ADDR_W; must satisfy ADDR_W <= WIDTH-1.
- TURNAROUND, 1, number of high-Z cycles between the read command and the responder driving the bus; minimum 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- bus  inout  WIDTH  shared tristate bus.
- ctrl  input  1  far-end direction: 1 = far end drives bus, 0 = far end released bus.
- req  input  1  far end qualifies the bus word as command or data; sampled only when ctrl=1.
- rsp_vld  output  1  high for the single cycle the responder drives read data.
- wr_valid  output  1  one-cycle pulse when a write is committed.
- wr_addr  output  ADDR_W  address of the committed write.
- wr_data  output  WIDTH  data of the committed write.
- busy  output  1  high in any state other than IDLE.
- err  output  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; bus=Z; rsp_vld, wr_valid, busy, err = 0; wr_addr, wr_data = 0.
  - All DEPTH registers = 0.
  - Reset mid-read releases the bus immediately (asynchronously).
- Bus drive: bus = drive_en ? rd_q : Z. drive_en and rd_q are registers; no combinational path from inputs to bus.
- Command word fields: bit WIDTH-1 = rw (1=read, 0=write); bits ADDR_W-1:0 = addr; remaining bits ignored.
- IDLE:
  - ctrl=1 and req=1 at edge k: capture addr.
  - rw=0 -> WR_DATA; rw=1 -> TA with turnaround counter=0.
  - Otherwise stay in IDLE.
- WR_DATA:
  - ctrl=1 and req=1: write bus into reg[addr]; wr_valid=1, wr_addr, wr_data valid for exactly one cycle after the edge; -> IDLE.
  - ctrl=1 and req=0: wait in WR_DATA, no timeout.
  - ctrl=0: abort, no write, err pulse; -> IDLE.
- TA:
  - bus stays Z; counter increments each cycle.
  - At edge k+TURNAROUND: drive_en=1, rd_q=reg[addr], rsp_vld=1; -> DRIVE.
- DRIVE:
  - Lasts exactly one cycle.
  - At the next edge: drive_en=0, rsp_vld=0; -> IDLE.
  - Read data occupies bus from edge k+TURNAROUND to edge k+TURNAROUND+1.
- req while busy (TA/DRIVE) is ignored; no queuing of commands.
- Back-to-back frames: a new command is accepted on the first edge in IDLE.
- Address wrap: not applicable; addr is always in range because DEPTH = 2**ADDR_W.
- Write then read of the same address returns the new value (write committed before IDLE).

Optional Feature:
- Macro BIDIR_CONTENTION_DET_EN.
- Defined:
  - In TA or DRIVE, ctrl=1 sampled means far end is driving.
  - Response: drive_en forced 0 at that edge, no rsp_vld, err pulse one cycle; -> IDLE.
  - Adds output err_cnt [7:0]: counts such events, saturates at 255, reset 0.
- Undefined:
  - ctrl is ignored in TA and DRIVE; the read completes normally.
  - No err_cnt port.
  - The err pulse is still raised for a WR_DATA abort.

Test Plan:
- Reset then idle: rst_n=0 -> bus=Z, all outputs 0; read of each addr 0..7 returns 0x00.
- Write: ctrl=1, req=1, bus=0x05 (write, addr 5); next cycle req=1, bus=0xA5 -> wr_valid one cycle with wr_addr=5, wr_data=0xA5; busy high for 1 cycle.
- Readback: cmd 0x85 at edge k, ctrl=0 the next cycle, TURNAROUND=1 -> bus Z for cycle k..k+1, then bus=0xA5 with rsp_vld=1 for exactly one cycle, then Z.
- Write abort: write cmd addr 2, then ctrl=0 before data -> err pulse, no wr_valid; reg[2] unchanged (0x00).
- Contention (macro defined): read cmd, ctrl held 1 through TA -> bus never driven, rsp_vld stays 0, err pulse, err_cnt=1. Macro undefined: bus=reg data with rsp_vld=1.
- Async reset asserted during DRIVE -> bus Z immediately, state IDLE; rsp_vld=0 without waiting for a clock edge.
